// File: rtl/cache_mem_arbiter.sv
// Shares one pmem cacheline port between the icache and dcache, one line transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed dcache priority.
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   localparam logic GRANT_D = 1'b0;
   localparam logic GRANT_I = 1'b1;

   state_t            state, state_next;
   logic              last_grant, last_grant_next;
   logic [ADDR_W-1:0] addr_q, addr_next;
   logic [LINE_W-1:0] wdata_q, wdata_next;
   logic              op_write_q, op_write_next;
   logic              i_req, d_req, grant_i, grant_d;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant_i = (last_grant == GRANT_D);
         grant_d = ~grant_i;
`else
         grant_d = 1'b1;
`endif
      end else begin
         grant_i = i_req;
         grant_d = d_req;
      end
   end

   // A simultaneous read+write from the dcache is treated as a write-back.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      addr_next       = addr_q;
      wdata_next      = wdata_q;
      op_write_next   = op_write_q;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_next    = SERVE_D;
               addr_next     = d_addr;
               wdata_next    = d_wdata;
               op_write_next = d_write;
            end else if (grant_i) begin
               state_next    = SERVE_I;
               addr_next     = i_addr;
               wdata_next    = '0;
               op_write_next = 1'b0;
            end
         end
         SERVE_I: begin
            if (pmem_resp) begin
               state_next      = IDLE;
               last_grant_next = GRANT_I;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               state_next      = IDLE;
               last_grant_next = GRANT_D;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GRANT_D;
         addr_q     <= '0;
         wdata_q    <= '0;
         op_write_q <= 1'b0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         addr_q     <= addr_next;
         wdata_q    <= wdata_next;
         op_write_q <= op_write_next;
      end
   end

   // Responses and read data are forwarded combinationally in the pmem_resp cycle.
   always_comb begin
      pmem_addr  = '0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_wdata = '0;
      i_resp     = 1'b0;
      i_rdata    = '0;
      d_resp     = 1'b0;
      d_rdata    = '0;
      case (state)
         SERVE_I: begin
            pmem_addr = addr_q;
            pmem_read = 1'b1;
            if (pmem_resp) begin
               i_resp  = 1'b1;
               i_rdata = pmem_rdata;
            end
         end
         SERVE_D: begin
            pmem_addr  = addr_q;
            pmem_read  = ~op_write_q;
            pmem_write = op_write_q;
            pmem_wdata = wdata_q;
            if (pmem_resp) begin
               d_resp  = 1'b1;
               d_rdata = pmem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table of single transactions plus contention/reset sequences.
module tb_cache_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] i_addr, d_addr, pmem_addr;
   logic              i_read, d_read, d_write;
   logic [LINE_W-1:0] d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
   logic              i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

   int passCount  = 0;
   int checkCount = 0;

   typedef struct {
      string             name;
      logic              isD;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
      int                delay;
   } vec_t;

   vec_t vecs[4];

   cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic checkAddr(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic checkLine(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      i_read     = 1'b0;
      d_read     = 1'b0;
      d_write    = 1'b0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
   endtask

   task automatic doReset;
      rst = 1'b0;
      idleInputs();
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Caller is in a SERVE cycle; checks address, pulses pmem_resp, checks the routed resp, returns in IDLE.
   task automatic serveOne(input string name, input logic expD, input logic [ADDR_W-1:0] expAddr);
      checkAddr({name, " pmem_addr"}, pmem_addr, expAddr);
      pmem_resp  = 1'b1;
      pmem_rdata = {8{32'h0BAD_F00D}};
      #1;
      checkBit({name, " d_resp"}, d_resp, expD);
      checkBit({name, " i_resp"}, i_resp, !expD);
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      #1;
   endtask

   // Single-requester transaction with a memory that answers after v.delay strobe cycles.
   task automatic applyStimulus(input vec_t v);
      logic held;
      if (v.isD) begin
         d_addr  = v.addr;
         d_wdata = v.wdata;
         d_read  = !v.wr;
         d_write = v.wr;
      end else begin
         i_addr = v.addr;
         i_read = 1'b1;
      end
      tick();
      checkBit ({v.name, " pmem_read"},  pmem_read,  !v.wr);
      checkBit ({v.name, " pmem_write"}, pmem_write, v.wr);
      checkAddr({v.name, " pmem_addr"},  pmem_addr,  v.addr);
      checkLine({v.name, " pmem_wdata"}, pmem_wdata, v.isD ? v.wdata : '0);
      held = 1'b1;
      for (int k = 1; k < v.delay; k++) begin
         tick();
         if (pmem_addr !== v.addr || pmem_read !== !v.wr || pmem_write !== v.wr ||
             i_resp !== 1'b0 || d_resp !== 1'b0)
            held = 1'b0;
      end
      checkBit({v.name, " strobes held until resp"}, held, 1'b1);
      pmem_resp  = 1'b1;
      pmem_rdata = v.rdata;
      #1;
      checkOutput(v);
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      i_read     = 1'b0;
      d_read     = 1'b0;
      d_write    = 1'b0;
      #1;
      checkBit({v.name, " resp one cycle i"}, i_resp, 1'b0);
      checkBit({v.name, " resp one cycle d"}, d_resp, 1'b0);
      checkBit({v.name, " idle strobes"}, pmem_read | pmem_write, 1'b0);
      tick();
   endtask

   task automatic checkOutput(input vec_t v);
      checkBit ({v.name, " i_resp"},  i_resp,  !v.isD);
      checkBit ({v.name, " d_resp"},  d_resp,  v.isD);
      checkLine({v.name, " i_rdata"}, i_rdata, v.isD ? '0 : v.rdata);
      checkLine({v.name, " d_rdata"}, d_rdata, v.isD ? v.rdata : '0);
   endtask

   initial begin
      logic [ADDR_W-1:0] firstAddr, secondAddr;
      logic              firstD, expD;

      vecs[0] = '{"icache read 0x60",  1'b0, 1'b0, 32'h0000_0060, '0, {8{32'hA5A5_A5A5}}, 3};
      vecs[1] = '{"dcache wb 0x1F00",  1'b1, 1'b1, 32'h0000_1F00, {16{16'h1234}}, {8{32'h5555_AAAA}}, 5};
      vecs[2] = '{"dcache read 0x2000", 1'b1, 1'b0, 32'h0000_2000, {8{32'hFFFF_0000}}, {8{32'hDEAD_BEEF}}, 2};
      vecs[3] = '{"icache read top",   1'b0, 1'b0, 32'hFFFF_FFE0, '0, {LINE_W{1'b1}}, 1};

      i_addr  = '0;
      d_addr  = '0;
      d_wdata = '0;
      idleInputs();

      // Reset holds everything quiet even with requests and a stray pmem_resp present.
      rst        = 1'b0;
      i_read     = 1'b1;
      d_write    = 1'b1;
      pmem_resp  = 1'b1;
      pmem_rdata = {8{32'h1111_2222}};
      tick();
      tick();
      checkBit ("reset pmem_read",  pmem_read,  1'b0);
      checkBit ("reset pmem_write", pmem_write, 1'b0);
      checkAddr("reset pmem_addr",  pmem_addr,  '0);
      checkLine("reset pmem_wdata", pmem_wdata, '0);
      checkBit ("reset i_resp",     i_resp,     1'b0);
      checkBit ("reset d_resp",     d_resp,     1'b0);
      checkLine("reset i_rdata",    i_rdata,    '0);
      checkLine("reset d_rdata",    d_rdata,    '0);
      idleInputs();
      rst = 1'b1;
      tick();

      for (int n = 0; n < 4; n++) applyStimulus(vecs[n]);

      // Simultaneous requests right after reset (last_grant is D).
      doReset();
      i_addr = 32'h0000_0040;
      d_addr = 32'h0000_0080;
      i_read = 1'b1;
      d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      firstD = 1'b0; firstAddr = 32'h40; secondAddr = 32'h80;
`else
      firstD = 1'b1; firstAddr = 32'h80; secondAddr = 32'h40;
`endif
      tick();
      serveOne("contend first", firstD, firstAddr);
      if (firstD) d_read = 1'b0;
      else i_read = 1'b0;
      checkBit("contend gap idle", pmem_read | pmem_write, 1'b0);
      tick();
      checkBit("contend second pmem_read", pmem_read, 1'b1);
      serveOne("contend second", !firstD, secondAddr);
      idleInputs();
      tick();

      // Both requesters held across four transactions.
      doReset();
      i_read = 1'b1;
      d_read = 1'b1;
      for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
         expD = (t % 2 == 1);
`else
         expD = 1'b1;
`endif
         tick();
         serveOne($sformatf("b2b grant %0d", t), expD, expD ? 32'h80 : 32'h40);
      end
      idleInputs();
      tick();

      // Reset in the second SERVE_D cycle abandons the transaction.
      d_addr = 32'h0000_0200;
      d_read = 1'b1;
      tick();
      checkBit("midrst serving pmem_read", pmem_read, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      checkBit("midrst pmem_read dropped", pmem_read, 1'b0);
      pmem_resp  = 1'b1;
      pmem_rdata = {8{32'h7777_7777}};
      #1;
      checkBit("midrst d_resp", d_resp, 1'b0);
      checkLine("midrst d_rdata", d_rdata, '0);
      rst = 1'b1;
      idleInputs();
      tick();
      checkBit("midrst after release d_resp", d_resp, 1'b0);
      checkBit("midrst after release strobes", pmem_read | pmem_write, 1'b0);
      i_addr = 32'h0000_0300;
      i_read = 1'b1;
      tick();
      checkBit("midrst new i pmem_read", pmem_read, 1'b1);
      serveOne("midrst new i", 1'b0, 32'h300);
      i_read = 1'b0;
      tick();

      // Stray pmem_resp while idle must not produce any response.
      pmem_resp  = 1'b1;
      pmem_rdata = {LINE_W{1'b1}};
      #1;
      checkBit ("spurious i_resp",  i_resp,  1'b0);
      checkBit ("spurious d_resp",  d_resp,  1'b0);
      checkLine("spurious i_rdata", i_rdata, '0);
      checkLine("spurious d_rdata", d_rdata, '0);
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      #1;
      checkBit("spurious stays idle", pmem_read | pmem_write, 1'b0);
      i_addr = 32'h0000_0400;
      i_read = 1'b1;
      tick();
      checkBit("spurious then grant pmem_read", pmem_read, 1'b1);
      serveOne("spurious then grant", 1'b0, 32'h400);
      i_read = 1'b0;
      tick();

      // Illegal read+write from the dcache behaves as a write-back.
      $display("[TB] note: driving d_read and d_write together (illegal), expecting a write-back");
      d_addr  = 32'h0000_0500;
      d_wdata = {8{32'hCAFE_0001}};
      d_read  = 1'b1;
      d_write = 1'b1;
      tick();
      checkBit ("illegal pmem_write", pmem_write, 1'b1);
      checkBit ("illegal pmem_read",  pmem_read,  1'b0);
      checkLine("illegal pmem_wdata", pmem_wdata, {8{32'hCAFE_0001}});
      serveOne("illegal", 1'b1, 32'h500);
      idleInputs();
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
